// File: rtl/peripheral_acc_mc.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_acc_mc
// Brief    : Multi-channel accumulator peripheral (sum/count/max/ovf per channel)
//            with a sequential restoring divider for averages.
//            Define PERIPH_ACC_SAT_EN to saturate sums on overflow (wrap otherwise).
// Revision : 1.0
// ============================================================================
module peripheral_acc_mc #(
   parameter int DATA_W   = 32,
   parameter int ACC_W    = 32,
   parameter int CNT_W    = 32,
   parameter int CHANNELS = 4,
   localparam int c_CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          opcode,
   input  logic [c_CHAN_W-1:0] chan,
   input  logic [DATA_W-1:0]   periwrite,
   output logic [ACC_W-1:0]    periread,
   output logic                rd_valid,
   output logic                busy,
   output logic [CHANNELS-1:0] ovf
);

   localparam logic [2:0] c_OP_CLEAR     = 3'd0;
   localparam logic [2:0] c_OP_ACCUM     = 3'd1;
   localparam logic [2:0] c_OP_READ_SUM  = 3'd2;
   localparam logic [2:0] c_OP_READ_CNT  = 3'd3;
   localparam logic [2:0] c_OP_READ_ZERO = 3'd4;
   localparam logic [2:0] c_OP_READ_MAX  = 3'd5;
   localparam logic [2:0] c_OP_READ_AVG  = 3'd6;
   localparam logic [2:0] c_OP_CLEAR_ALL = 3'd7;

   localparam int              c_IT_W = $clog2(ACC_W);
   localparam logic [c_IT_W-1:0] c_IT_LAST = c_IT_W'(ACC_W - 1);
   localparam logic [c_CHAN_W:0] c_NCH = (c_CHAN_W + 1)'(CHANNELS);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_DIV  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ACC_W-1:0]    r_sum [CHANNELS];
   logic [CNT_W-1:0]    r_cnt [CHANNELS];
   logic [DATA_W-1:0]   r_max [CHANNELS];
   logic [CHANNELS-1:0] r_ovf;

   logic [ACC_W-1:0]    r_quo;
   logic [ACC_W-1:0]    r_rem;
   logic [ACC_W-1:0]    r_dvs;
   logic [c_IT_W-1:0]   r_iter;

   logic                w_idle;
   logic                w_chan_ok;
   logic                w_start;
   logic                w_last;
   logic [ACC_W-1:0]    w_sel_sum;
   logic [CNT_W-1:0]    w_sel_cnt;
   logic [DATA_W-1:0]   w_sel_max;
   logic [ACC_W:0]      w_add;
   logic [ACC_W-1:0]    w_sum_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [ACC_W:0]      w_trial;
   logic                w_ge;
   logic [ACC_W-1:0]    w_diff;
   logic [ACC_W-1:0]    w_quo_nxt;

   assign w_idle    = (r_state == S_IDLE);
   assign w_chan_ok = ({1'b0, chan} < c_NCH);

   // Out-of-range channels read as zero and are never written.
   assign w_sel_sum = w_chan_ok ? r_sum[chan] : '0;
   assign w_sel_cnt = w_chan_ok ? r_cnt[chan] : '0;
   assign w_sel_max = w_chan_ok ? r_max[chan] : '0;

   assign w_add = {1'b0, w_sel_sum} + (ACC_W + 1)'(periwrite);
`ifdef PERIPH_ACC_SAT_EN
   assign w_sum_nxt = w_add[ACC_W] ? '1 : w_add[ACC_W-1:0];
`else
   assign w_sum_nxt = w_add[ACC_W-1:0];
`endif
   assign w_cnt_nxt = (w_sel_cnt == '1) ? w_sel_cnt : w_sel_cnt + CNT_W'(1);

   assign w_start = w_idle && (opcode == c_OP_READ_AVG) && w_chan_ok && (w_sel_cnt != '0);
   assign w_last  = (r_iter == c_IT_LAST);

   // Restoring divider: r_quo starts as the dividend and shifts quotient bits in.
   assign w_trial   = {r_rem, r_quo[ACC_W-1]};
   assign w_ge      = (w_trial >= {1'b0, r_dvs});
   assign w_diff    = w_trial[ACC_W-1:0] - r_dvs;
   assign w_quo_nxt = {r_quo[ACC_W-2:0], w_ge};

   assign busy = (r_state == S_DIV);
   assign ovf  = r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_DIV;
         S_DIV:   if (w_last)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_sum[i] <= '0;
            r_cnt[i] <= '0;
            r_max[i] <= '0;
         end
         r_ovf <= '0;
      end else if (w_idle) begin
         if (opcode == c_OP_CLEAR_ALL) begin
            for (int i = 0; i < CHANNELS; i++) begin
               r_sum[i] <= '0;
               r_cnt[i] <= '0;
               r_max[i] <= '0;
            end
            r_ovf <= '0;
         end else if (w_chan_ok) begin
            if (opcode == c_OP_CLEAR) begin
               r_sum[chan] <= '0;
               r_cnt[chan] <= '0;
               r_max[chan] <= '0;
               r_ovf[chan] <= 1'b0;
            end else if (opcode == c_OP_ACCUM) begin
               r_sum[chan] <= w_sum_nxt;
               r_cnt[chan] <= w_cnt_nxt;
               if (periwrite > w_sel_max) r_max[chan] <= periwrite;
               if (w_add[ACC_W]) r_ovf[chan] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         periread <= '0;
         rd_valid <= 1'b0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_dvs    <= '0;
         r_iter   <= '0;
      end else begin
         rd_valid <= 1'b0;
         if (r_state == S_DIV) begin
            r_rem  <= w_ge ? w_diff : w_trial[ACC_W-1:0];
            r_quo  <= w_quo_nxt;
            r_iter <= r_iter + c_IT_W'(1);
            if (w_last) begin
               periread <= w_quo_nxt;
               rd_valid <= 1'b1;
            end
         end else begin
            case (opcode)
               c_OP_READ_SUM: begin
                  periread <= w_sel_sum;
                  rd_valid <= 1'b1;
               end
               c_OP_READ_CNT: begin
                  periread <= ACC_W'(w_sel_cnt);
                  rd_valid <= 1'b1;
               end
               c_OP_READ_ZERO: begin
                  periread <= '0;
                  rd_valid <= 1'b1;
               end
               c_OP_READ_MAX: begin
                  periread <= ACC_W'(w_sel_max);
                  rd_valid <= 1'b1;
               end
               c_OP_READ_AVG: begin
                  if (w_start) begin
                     r_quo  <= w_sel_sum;
                     r_rem  <= '0;
                     r_dvs  <= ACC_W'(w_sel_cnt);
                     r_iter <= '0;
                  end else begin
                     periread <= '0;
                     rd_valid <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_acc_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_acc_mc
// Brief    : Scoreboard bench for peripheral_acc_mc against a per-channel model.
// Revision : 1.0
// ============================================================================
module tb_peripheral_acc_mc;

   localparam int DATA_W   = 32;
   localparam int ACC_W    = 32;
   localparam int CNT_W    = 32;
   localparam int CHANNELS = 4;
   localparam longint unsigned c_MAX32 = 64'h0000_0000_FFFF_FFFF;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0]        opcode;
   logic [1:0]        chan;
   logic [DATA_W-1:0] periwrite;
   logic [ACC_W-1:0]  periread;
   logic              rd_valid;
   logic              busy;
   logic [CHANNELS-1:0] ovf;

   always #5 clk = ~clk;

   peripheral_acc_mc #(
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W),
      .CNT_W    (CNT_W),
      .CHANNELS (CHANNELS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .chan      (chan),
      .periwrite (periwrite),
      .periread  (periread),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .ovf       (ovf)
   );

   int total = 0;
   int bad   = 0;

   logic [ACC_W-1:0] exp_q[$];

   longint unsigned  m_sum [CHANNELS];
   longint unsigned  m_cnt [CHANNELS];
   longint unsigned  m_max [CHANNELS];
   logic [CHANNELS-1:0] m_ovf;
   int               busy_left;
   logic             exp_rv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear(input int c);
      m_sum[c] = 0;
      m_cnt[c] = 0;
      m_max[c] = 0;
      m_ovf[c] = 1'b0;
   endtask

   task automatic model_reset();
      for (int c = 0; c < CHANNELS; c++) model_clear(c);
      busy_left = 0;
      exp_rv    = 1'b0;
      exp_q.delete();
   endtask

   // Monitor: every rd_valid pulse consumes one expected read result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rd_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("spurious_rd_valid", {63'b0, rd_valid}, 64'd0);
         else chk("periread", periread, exp_q.pop_front());
      end
   end

   // One opcode per clock; the model decides what the DUT must do with it.
   task automatic issue(input logic [2:0] op, input int c, input logic [DATA_W-1:0] d);
      longint unsigned s;
      @(posedge clk);
      #1;
      chk("busy", busy, busy_left > 0);
      chk("ovf", ovf, m_ovf);
      chk("rd_valid", rd_valid, exp_rv);
      opcode    = op;
      chan      = c[1:0];
      periwrite = d;
      exp_rv    = 1'b0;
      if (busy_left > 0) begin
         if (busy_left == 1) exp_rv = 1'b1;
         busy_left--;
         return;
      end
      case (op)
         3'd0: model_clear(c);
         3'd1: begin
            s = m_sum[c] + longint'(d);
            if (s > c_MAX32) begin
               m_ovf[c] = 1'b1;
`ifdef PERIPH_ACC_SAT_EN
               s = c_MAX32;
`else
               s = s - c_MAX32 - 1;
`endif
            end
            m_sum[c] = s;
            if (m_cnt[c] < c_MAX32) m_cnt[c] = m_cnt[c] + 1;
            if (longint'(d) > m_max[c]) m_max[c] = longint'(d);
         end
         3'd2: begin exp_q.push_back(32'(m_sum[c])); exp_rv = 1'b1; end
         3'd3: begin exp_q.push_back(32'(m_cnt[c])); exp_rv = 1'b1; end
         3'd4: begin exp_q.push_back('0);            exp_rv = 1'b1; end
         3'd5: begin exp_q.push_back(32'(m_max[c])); exp_rv = 1'b1; end
         3'd6: begin
            if (m_cnt[c] == 0) begin
               exp_q.push_back('0);
               exp_rv = 1'b1;
            end else begin
               exp_q.push_back(32'(m_sum[c] / m_cnt[c]));
               busy_left = ACC_W;
            end
         end
         default: for (int k = 0; k < CHANNELS; k++) model_clear(k);
      endcase
   endtask

   task automatic reset_mid();
      #2 rst_n = 1'b0;
      #1;
      chk("busy_in_reset", busy, 64'd0);
      chk("periread_in_reset", periread, 64'd0);
      chk("rd_valid_in_reset", rd_valid, 64'd0);
      chk("ovf_in_reset", ovf, 64'd0);
      model_reset();
      opcode = 3'd7;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic read_all();
      for (int c = 0; c < CHANNELS; c++) begin
         issue(3'd2, c, '0);
         issue(3'd3, c, '0);
         issue(3'd5, c, '0);
      end
   endtask

   initial begin
      int r;
      logic [DATA_W-1:0] d;
      rst_n     = 1'b0;
      opcode    = 3'd7;
      chan      = '0;
      periwrite = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_periread", periread, 64'd0);
      chk("reset_rd_valid", rd_valid, 64'd0);
      chk("reset_busy", busy, 64'd0);
      chk("reset_ovf", ovf, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      read_all();

      issue(3'd1, 2, 32'd10);
      issue(3'd1, 2, 32'd30);
      issue(3'd1, 2, 32'd20);
      issue(3'd2, 2, '0);
      issue(3'd3, 2, '0);
      issue(3'd5, 2, '0);
      issue(3'd2, 1, '0);
      issue(3'd3, 1, '0);

      issue(3'd1, 0, 32'd100);
      issue(3'd1, 0, 32'd7);
      issue(3'd6, 0, '0);
      for (int i = 0; i < ACC_W; i++) issue(3'd1, 0, 32'd5);
      issue(3'd3, 0, '0);
      issue(3'd2, 0, '0);

      issue(3'd1, 3, 32'hFFFF_FFF0);
      issue(3'd1, 3, 32'h0000_0020);
      issue(3'd2, 3, '0);
      issue(3'd1, 3, 32'd1);
      issue(3'd2, 3, '0);
      issue(3'd0, 3, '0);
      issue(3'd6, 3, '0);
      issue(3'd2, 3, '0);

      issue(3'd7, 0, '0);
      for (int c = 0; c < CHANNELS; c++) issue(3'd3, c, '0);

      issue(3'd1, 1, 32'd1000);
      issue(3'd1, 1, 32'd3);
      issue(3'd6, 1, '0);
      for (int i = 0; i < 5; i++) issue(3'd4, 1, '0);
      reset_mid();
      read_all();

      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 99));
         d = (r % 3 == 0) ? $urandom() : DATA_W'($urandom_range(0, 1000));
         if (r < 45)      issue(3'd1, int'($urandom_range(0, 3)), d);
         else if (r < 50) issue(3'd0, int'($urandom_range(0, 3)), d);
         else if (r < 52) issue(3'd7, int'($urandom_range(0, 3)), d);
         else if (r < 60) issue(3'd6, int'($urandom_range(0, 3)), d);
         else             issue(3'($urandom_range(2, 5)), int'($urandom_range(0, 3)), d);
      end

      while (busy_left > 0) issue(3'd7, 0, '0);
      issue(3'd7, 0, '0);
      issue(3'd7, 0, '0);
      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/peripheral_acc_mc.md
# peripheral_acc_mc

Parametrised multi-channel accumulator peripheral driven by the processor's 3-bit peripheral opcode bus. Keeps per-channel running sum, sample count, maximum and sticky overflow; supports clear, accumulate and registered reads, plus a multi-cycle average (sum / count) computed by an internal sequential restoring divider. Sits on the datapath's peripheral port, in place of the single-channel sum/counter peripheral.

## Interface
- DATA_W, 32, width of write data (unsigned samples)
- ACC_W, 32, width of each sum register and of periread; ACC_W >= DATA_W
- CNT_W, 32, width of each sample counter; CNT_W <= ACC_W
- CHANNELS, 4, number of independent channels (>= 1)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  3  command, sampled every rising edge when busy = 0
- chan  in  max(1,$clog2(CHANNELS))  channel select
- periwrite  in  DATA_W  sample for ACCUM
- periread  out  ACC_W  registered read data; holds last value between reads
- rd_valid  out  1  one-cycle pulse: periread updated this cycle
- busy  out  1  divider running; opcodes ignored
- ovf  out  CHANNELS  sticky per-channel sum-overflow flags

## Operation
- Opcodes: 0 CLEAR (sum, count, max, ovf of chan <= 0); 1 ACCUM; 2 READ_SUM; 3 READ_CNT; 4 READ_ZERO (periread <= 0); 5 READ_MAX; 6 READ_AVG; 7 CLEAR_ALL (every channel cleared, chan ignored).
- ACCUM: sum += zero-extended periwrite; count += 1, saturating at 2^CNT_W-1; max <= periwrite if periwrite > max.
- Sum carry out of bit ACC_W-1 sets ovf[chan]; sum result per Configuration.
- Reads 2,3,4,5 return the selected channel's pre-edge value; count zero-extended to ACC_W.
- READ_AVG: snapshot sum (dividend) and count (divisor) of chan; if count = 0, result is 0 immediately; else divider FSM IDLE -> DIV (ACC_W iterations, one quotient bit per edge, MSB first) -> IDLE; quotient = floor(sum/count).
- chan >= CHANNELS: writes/clears ignored; reads return 0 with rd_valid.
- All opcodes during busy = 1 are ignored (no state change, no rd_valid); software polls busy.
- Reset values: all sums, counts, max, ovf, periread = 0; rd_valid = 0; busy = 0; FSM = IDLE.

## Timing
- CLEAR/ACCUM/CLEAR_ALL at edge k: registers updated at edge k; a read at edge k+1 sees the new value.
- Reads 2,3,4,5 at edge k: periread and rd_valid = 1 after edge k, rd_valid low after edge k+1 unless another read.
- Read and ACCUM are exclusive (one opcode per cycle); back-to-back ACCUMs every cycle supported.
- READ_AVG, count > 0, at edge k: busy = 1 after edge k; iterations at edges k+1..k+ACC_W; at edge k+ACC_W periread = quotient, rd_valid = 1, busy = 0. Next opcode accepted at edge k+ACC_W+1.
- READ_AVG, count = 0: behaves as a single-cycle read of 0; busy never asserted.
- Snapshot taken at edge k; later channel updates do not affect the running division.
- rst_n low at any time (including mid-division): immediate return to reset values; aborted division produces no rd_valid.

## Configuration
- PERIPH_ACC_SAT_EN defined: on overflow, sum saturates to 2^ACC_W-1 and stays there until CLEAR; ovf set.
- Not defined: sum wraps modulo 2^ACC_W; ovf set. Counter saturation and all other behaviour identical in both builds.

## Test plan
- Reset, then READ_SUM/READ_CNT/READ_MAX on ch0..3 -> periread = 0, rd_valid one cycle each, ovf = 0, busy = 0.
- ch2: ACCUM 10, 30, 20 then READ_SUM, READ_CNT, READ_MAX -> 60, 3, 30; ch1 reads remain 0.
- ch0: ACCUM 100, 7 then READ_AVG -> busy for ACC_W cycles, then periread = 53, rd_valid one cycle; opcode 1 issued while busy leaves count = 2.
- ch3: ACCUM 0xFFFFFFF0 then 0x20 (ACC_W = 32) -> ovf[3] = 1; READ_SUM = 0x00000010 without PERIPH_ACC_SAT_EN, 0xFFFFFFFF with it; CLEAR ch3 -> ovf[3] = 0.
- READ_AVG on cleared channel -> periread = 0 one cycle later, busy stays 0; CLEAR_ALL then READ_CNT on all channels -> 0.
- Start READ_AVG, assert rst_n low after 5 cycles -> busy = 0, periread = 0, no rd_valid; all channels read 0 after release.
